// File: rtl/scope_capture_if.sv
// Avalon-MM style 16-bit configuration/status bus shared by the scope top level
// and the trigger/capture engine.
interface scope_capture_if;
   logic        chipselect;
   logic        write;
   logic        read;
   logic [2:0]  address;
   logic [15:0] writedata;
   logic [15:0] readdata;

   modport master (output chipselect, write, read, address, writedata, input readdata);
   modport slave  (input chipselect, write, read, address, writedata, output readdata);
endinterface

// File: rtl/scope_capture.sv
// N-channel trigger/capture engine: decimates the ADC stream, keeps a circular
// pre-trigger history, detects level/edge triggers and freezes one frame for readout.
module scope_capture #(
   parameter int NUM_CH       = 2,
   parameter int SAMPLE_W     = 12,
   parameter int DEPTH        = 640,
   parameter int AUTO_TIMEOUT = 2048,
   localparam int ADDR_W      = $clog2(DEPTH),
   localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   scope_capture_if.slave             bus,
   input  logic                       sample_valid,
   input  logic [NUM_CH*SAMPLE_W-1:0] sample_data,
   input  logic [CH_W-1:0]            rd_ch,
   input  logic [ADDR_W-1:0]          rd_addr,
   output logic [SAMPLE_W-1:0]        rd_data,
   output logic                       triggered,
   output logic                       frame_ready
);

   localparam int AT_W = $clog2(AUTO_TIMEOUT + 1);
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_t;

   function automatic logic [15:0] fix_decim(input logic [15:0] d);
      return (d == 16'd0) ? 16'd1 : d;
   endfunction

   function automatic logic [ADDR_W-1:0] sat_pretrig(input logic [15:0] p);
      if (p >= 16'(DEPTH - 1)) return ADDR_W'(DEPTH - 1);
      return p[ADDR_W-1:0];
   endfunction

   function automatic logic [ADDR_W:0] wrap_depth(input logic [ADDR_W:0] v);
      return (v >= DEPTH_X) ? v - DEPTH_X : v;
   endfunction

   function automatic logic [SAMPLE_W-1:0] chan_sel(input logic [NUM_CH*SAMPLE_W-1:0] word,
                                                    input int c);
      logic [SAMPLE_W-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (i == c) r = word[i*SAMPLE_W +: SAMPLE_W];
      return r;
   endfunction

   state_t                      state_q, state_d;
   logic [6:0]                  ctrl_q, ctrl_d;
   logic [SAMPLE_W-1:0]         level_q, level_d;
   logic [15:0]                 decim_q, decim_d;
   logic [15:0]                 pretrig_q, pretrig_d;
   logic [15:0]                 w_decim_q, w_decim_d;
   logic [ADDR_W-1:0]           w_pretrig_q, w_pretrig_d;
   logic [SAMPLE_W-1:0]         w_level_q, w_level_d;
   logic [1:0]                  w_edge_q, w_edge_d;
   logic [3:0]                  w_ch_q, w_ch_d;
   logic                        w_auto_q, w_auto_d;
   logic [15:0]                 dec_cnt_q, dec_cnt_d;
   logic [ADDR_W-1:0]           wptr_q, wptr_d;
   logic [ADDR_W-1:0]           tptr_q, tptr_d;
   logic [ADDR_W-1:0]           cnt_q, cnt_d;
   logic [AT_W-1:0]             auto_cnt_q, auto_cnt_d;
   logic [SAMPLE_W-1:0]         prev_q, prev_d;
   logic                        prev_vld_q, prev_vld_d;
   logic                        triggered_q, triggered_d;
   logic                        frame_ready_q, frame_ready_d;
   logic [15:0]                 readdata_q, readdata_d;
   logic [SAMPLE_W-1:0]         rd_data_q, rd_data_d;
   logic                        wr_en;
   logic [NUM_CH*SAMPLE_W-1:0]  mem_q [DEPTH];

   logic                        bus_wr, bus_rd, arm, strobe, rise, fall, hit, force_trig;
   logic [SAMPLE_W-1:0]         cur;
   logic [ADDR_W-1:0]           post_target, wptr_inc;
   logic [1:0]                  state_code;
   logic [ADDR_W:0]             start, rd_mod, phys;

   assign bus_wr     = bus.chipselect & bus.write;
   assign bus_rd     = bus.chipselect & bus.read;
   assign arm        = bus_wr && (bus.address == 3'd0) && bus.writedata[0];
   assign strobe     = sample_valid && (({1'b0, dec_cnt_q} + 17'd1) >= {1'b0, w_decim_q});
   assign cur        = chan_sel(sample_data, int'(w_ch_q));
   assign rise       = prev_vld_q && (prev_q < w_level_q) && (w_level_q <= cur);
   assign fall       = prev_vld_q && (prev_q >= w_level_q) && (w_level_q > cur);
   assign hit        = (w_edge_q == 2'b01) ? fall : (w_edge_q == 2'b10) ? (rise | fall) : rise;
   assign force_trig = w_auto_q && (auto_cnt_q == AT_W'(AUTO_TIMEOUT - 1));
   assign post_target = ADDR_W'(DEPTH - 1) - w_pretrig_q;
   assign wptr_inc   = (wptr_q == ADDR_W'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;

   always_comb begin
      case (state_q)
         S_PRE:   state_code = 2'd1;
         S_ARMED: state_code = 2'd2;
         S_POST:  state_code = 2'd3;
         default: state_code = 2'd0;
      endcase
   end

   // Frame readout: index 0 is PRETRIG samples before the trigger sample.
   always_comb begin
      start  = ({1'b0, tptr_q} >= {1'b0, w_pretrig_q})
               ? {1'b0, tptr_q} - {1'b0, w_pretrig_q}
               : {1'b0, tptr_q} + DEPTH_X - {1'b0, w_pretrig_q};
      rd_mod = wrap_depth({1'b0, rd_addr});
      phys   = wrap_depth(start + rd_mod);
   end

   always_comb begin
      state_d       = state_q;
      ctrl_d        = ctrl_q;
      level_d       = level_q;
      decim_d       = decim_q;
      pretrig_d     = pretrig_q;
      w_decim_d     = w_decim_q;
      w_pretrig_d   = w_pretrig_q;
      w_level_d     = w_level_q;
      w_edge_d      = w_edge_q;
      w_ch_d        = w_ch_q;
      w_auto_d      = w_auto_q;
      dec_cnt_d     = dec_cnt_q;
      wptr_d        = wptr_q;
      tptr_d        = tptr_q;
      cnt_d         = cnt_q;
      auto_cnt_d    = auto_cnt_q;
      prev_d        = prev_q;
      prev_vld_d    = prev_vld_q;
      triggered_d   = triggered_q;
      frame_ready_d = frame_ready_q;
      readdata_d    = readdata_q;
      wr_en         = 1'b0;
      rd_data_d     = chan_sel(mem_q[phys[ADDR_W-1:0]], int'(rd_ch));

      if (bus_wr) begin
         case (bus.address)
            3'd0:    ctrl_d    = bus.writedata[7:1];
            3'd1:    level_d   = bus.writedata[SAMPLE_W-1:0];
            3'd2:    decim_d   = bus.writedata;
            3'd3:    pretrig_d = bus.writedata;
            default: ;
         endcase
      end

      if (bus_rd) begin
         case (bus.address)
            3'd0:    readdata_d = {8'h00, ctrl_q, 1'b0};
            3'd1:    readdata_d = 16'(level_q);
            3'd2:    readdata_d = decim_q;
            3'd3:    readdata_d = pretrig_q;
            3'd4:    readdata_d = {12'h000, triggered_q, frame_ready_q, state_code};
            default: readdata_d = 16'h0000;
         endcase
      end

      if (sample_valid) dec_cnt_d = strobe ? 16'd0 : dec_cnt_q + 16'd1;

      case (state_q)
         S_PRE: begin
            if (w_pretrig_q == '0) begin
               state_d = S_ARMED;
            end else if (strobe) begin
               wr_en      = 1'b1;
               wptr_d     = wptr_inc;
               prev_d     = cur;
               prev_vld_d = 1'b1;
               cnt_d      = cnt_q + 1'b1;
               if (cnt_q == w_pretrig_q - 1'b1) begin
                  state_d = S_ARMED;
                  cnt_d   = '0;
               end
            end
         end
         S_ARMED: begin
            if (strobe) begin
               wr_en      = 1'b1;
               wptr_d     = wptr_inc;
               prev_d     = cur;
               prev_vld_d = 1'b1;
               auto_cnt_d = auto_cnt_q + 1'b1;
               if (hit || force_trig) begin
                  tptr_d      = wptr_q;
                  triggered_d = hit;
                  cnt_d       = '0;
                  if (post_target == '0) begin
                     state_d       = S_DONE;
                     frame_ready_d = 1'b1;
                  end else begin
                     state_d = S_POST;
                  end
               end
            end
         end
         S_POST: begin
            if (strobe) begin
               wr_en  = 1'b1;
               wptr_d = wptr_inc;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == post_target - 1'b1) begin
                  state_d       = S_DONE;
                  frame_ready_d = 1'b1;
               end
            end
         end
         default: ;
      endcase

      // Arm overrides anything else happening this cycle, including a trigger.
      if (arm) begin
         state_d       = S_PRE;
         w_decim_d     = fix_decim(decim_q);
         w_pretrig_d   = sat_pretrig(pretrig_q);
         w_level_d     = level_q;
         w_edge_d      = bus.writedata[3:2];
         w_ch_d        = (int'(bus.writedata[7:4]) >= NUM_CH) ? 4'd0 : bus.writedata[7:4];
         w_auto_d      = bus.writedata[1];
         dec_cnt_d     = '0;
         wptr_d        = '0;
         cnt_d         = '0;
         auto_cnt_d    = '0;
         prev_vld_d    = 1'b0;
         triggered_d   = 1'b0;
         frame_ready_d = 1'b0;
         wr_en         = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         ctrl_q        <= '0;
         level_q       <= '0;
         decim_q       <= 16'd1;
         pretrig_q     <= '0;
         w_decim_q     <= 16'd1;
         w_pretrig_q   <= '0;
         w_edge_q      <= '0;
         w_ch_q        <= '0;
         w_auto_q      <= 1'b0;
         dec_cnt_q     <= '0;
         wptr_q        <= '0;
         cnt_q         <= '0;
         auto_cnt_q    <= '0;
         prev_vld_q    <= 1'b0;
         triggered_q   <= 1'b0;
         frame_ready_q <= 1'b0;
         readdata_q    <= '0;
         rd_data_q     <= '0;
      end else begin
         state_q       <= state_d;
         ctrl_q        <= ctrl_d;
         level_q       <= level_d;
         decim_q       <= decim_d;
         pretrig_q     <= pretrig_d;
         w_decim_q     <= w_decim_d;
         w_pretrig_q   <= w_pretrig_d;
         w_edge_q      <= w_edge_d;
         w_ch_q        <= w_ch_d;
         w_auto_q      <= w_auto_d;
         dec_cnt_q     <= dec_cnt_d;
         wptr_q        <= wptr_d;
         cnt_q         <= cnt_d;
         auto_cnt_q    <= auto_cnt_d;
         prev_vld_q    <= prev_vld_d;
         triggered_q   <= triggered_d;
         frame_ready_q <= frame_ready_d;
         readdata_q    <= readdata_d;
         rd_data_q     <= rd_data_d;
      end
      w_level_q <= w_level_d;
      tptr_q    <= tptr_d;
      prev_q    <= prev_d;
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wptr_q] <= sample_data;
   end

   assign bus.readdata = readdata_q;
   assign rd_data      = rd_data_q;
   assign triggered    = triggered_q;
   assign frame_ready  = frame_ready_q;

endmodule

// File: tb/tb_scope_capture.sv
// Directed bench for scope_capture: 2 channels, 12-bit samples, 16-deep frames,
// auto timeout of 32 strobes.
module tb_scope_capture;

   logic        clk;
   logic        reset;
   logic        sample_valid;
   logic [23:0] sample_data;
   logic        rd_ch;
   logic [3:0]  rd_addr;
   logic [11:0] rd_data;
   logic        triggered;
   logic        frame_ready;

   int n_assert;
   int n_fail;

   logic [15:0] rv;
   logic [11:0] sd;

   scope_capture_if bus ();

   scope_capture #(
      .NUM_CH(2), .SAMPLE_W(12), .DEPTH(16), .AUTO_TIMEOUT(32)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .sample_valid(sample_valid), .sample_data(sample_data),
      .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data),
      .triggered(triggered), .frame_ready(frame_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic reg_write(input logic [2:0] a, input logic [15:0] d);
      bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
      tick();
      bus.chipselect = 1'b0; bus.write = 1'b0;
   endtask

   task automatic reg_read(input logic [2:0] a, output logic [15:0] d);
      bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
      tick();
      bus.chipselect = 1'b0; bus.read = 1'b0;
      d = bus.readdata;
   endtask

   task automatic push(input logic [11:0] c0, input logic [11:0] c1);
      sample_valid = 1'b1; sample_data = {c1, c0};
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic rd_sample(input logic ch, input logic [3:0] a, output logic [11:0] d);
      rd_ch = ch; rd_addr = a;
      tick();
      d = rd_data;
   endtask

   initial begin
      n_assert = 0; n_fail = 0;
      reset = 1'b1; sample_valid = 1'b0; sample_data = '0; rd_ch = 1'b0; rd_addr = '0;
      bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
      bus.address = '0; bus.writedata = '0;
      tick(); tick();
      reset = 1'b0;

      // Reset state
      check("rst_frame_ready", 16'(frame_ready), 16'h0);
      check("rst_triggered", 16'(triggered), 16'h0);
      check("rst_rd_data", 16'(rd_data), 16'h0);
      check("rst_readdata", bus.readdata, 16'h0);
      reg_read(3'd2, rv); check("rst_decim", rv, 16'h0001);
      reg_read(3'd4, rv); check("rst_status", rv, 16'h0000);
      reg_read(3'd1, rv); check("rst_level", rv, 16'h0000);
      reg_read(3'd3, rv); check("rst_pretrig", rv, 16'h0000);
      reg_read(3'd6, rv); check("rd_unmapped", rv, 16'h0000);

      // Rising trigger on ch0 ramp
      reg_write(3'd1, 16'h0800);
      reg_write(3'd3, 16'h0004);
      reg_write(3'd0, 16'h0001);
      reg_read(3'd4, rv); check("t1_status_pre", rv, 16'h0001);
      for (int i = 0; i < 4; i++) push(12'(i * 256), 12'h000);
      reg_read(3'd4, rv); check("t1_status_armed", rv, 16'h0002);
      for (int i = 4; i < 8; i++) push(12'(i * 256), 12'h000);
      check("t1_trig_before", 16'(triggered), 16'h0);
      push(12'h800, 12'h000);
      check("t1_trig_after", 16'(triggered), 16'h1);
      for (int i = 9; i < 19; i++) push(12'(i * 256), 12'h000);
      check("t1_ready_early", 16'(frame_ready), 16'h0);
      push(12'h300, 12'h000);
      check("t1_ready", 16'(frame_ready), 16'h1);
      reg_read(3'd4, rv); check("t1_status_done", rv, 16'h000C);
      rd_sample(1'b0, 4'd4, sd); check("t1_rd4", 16'(sd), 16'h0800);
      rd_sample(1'b0, 4'd0, sd); check("t1_rd0", 16'(sd), 16'h0400);
      rd_sample(1'b0, 4'd15, sd); check("t1_rd15", 16'(sd), 16'h0300);
      rd_sample(1'b1, 4'd4, sd); check("t1_rd4_ch1", 16'(sd), 16'h0000);

      // Falling trigger on ch1; ch0 crosses the level earlier but is not selected
      reg_write(3'd0, 16'h0015);
      check("t2_ready_cleared", 16'(frame_ready), 16'h0);
      for (int i = 0; i < 8; i++) push(12'(32'hC00 - i * 256), 12'(32'hF00 - i * 256));
      check("t2_trig_before", 16'(triggered), 16'h0);
      push(12'h400, 12'h700);
      check("t2_trig_after", 16'(triggered), 16'h1);
      for (int i = 9; i < 20; i++) push(12'(32'hC00 - i * 256), 12'(32'hF00 - i * 256));
      check("t2_ready", 16'(frame_ready), 16'h1);
      rd_sample(1'b1, 4'd4, sd); check("t2_rd4_ch1", 16'(sd), 16'h0700);
      rd_sample(1'b1, 4'd0, sd); check("t2_rd0_ch1", 16'(sd), 16'h0B00);
      rd_sample(1'b0, 4'd4, sd); check("t2_rd4_ch0", 16'(sd), 16'h0400);

      // Decimation by 3: stored strobes are every third ramp sample
      reg_write(3'd2, 16'h0003);
      reg_write(3'd0, 16'h0001);
      for (int i = 0; i < 26; i++) push(12'(i * 256), 12'h000);
      check("t3_trig_before", 16'(triggered), 16'h0);
      push(12'hA00, 12'h000);
      check("t3_trig_after", 16'(triggered), 16'h1);
      for (int i = 27; i < 59; i++) push(12'(i * 256), 12'h000);
      check("t3_ready_early", 16'(frame_ready), 16'h0);
      push(12'(59 * 256), 12'h000);
      check("t3_ready", 16'(frame_ready), 16'h1);
      for (int k = 0; k < 5; k++) begin
         rd_sample(1'b0, 4'(k), sd);
         check($sformatf("t3_rd%0d", k), 16'(sd), 16'(12'(32'hE00 + k * 32'h300)));
      end
      rd_sample(1'b0, 4'd15, sd); check("t3_rd15", 16'(sd), 16'h0B00);

      // Auto mode with a flat input
      reg_write(3'd2, 16'h0001);
      reg_write(3'd0, 16'h0003);
      for (int i = 0; i < 35; i++) push(12'h100, 12'h100);
      reg_read(3'd4, rv); check("t4_status_armed", rv, 16'h0002);
      push(12'h100, 12'h100);
      reg_read(3'd4, rv); check("t4_status_post", rv, 16'h0003);
      check("t4_trig_forced", 16'(triggered), 16'h0);
      for (int i = 0; i < 10; i++) push(12'h100, 12'h100);
      check("t4_ready_early", 16'(frame_ready), 16'h0);
      push(12'h100, 12'h100);
      check("t4_ready", 16'(frame_ready), 16'h1);
      check("t4_triggered", 16'(triggered), 16'h0);
      rd_sample(1'b1, 4'd7, sd); check("t4_rd7_ch1", 16'(sd), 16'h0100);

      // Arm during POST aborts the frame
      reg_write(3'd0, 16'h0001);
      for (int i = 0; i < 11; i++) push(12'(i * 256), 12'h000);
      check("t5_trig_post", 16'(triggered), 16'h1);
      reg_write(3'd0, 16'h0001);
      check("t5_trig_cleared", 16'(triggered), 16'h0);
      check("t5_ready_cleared", 16'(frame_ready), 16'h0);
      reg_read(3'd4, rv); check("t5_status_pre", rv, 16'h0001);

      // Arm coinciding with a trigger sample wins
      for (int i = 0; i < 8; i++) push(12'(i * 256), 12'h000);
      bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 3'd0; bus.writedata = 16'h0001;
      sample_valid = 1'b1; sample_data = {12'h000, 12'h800};
      tick();
      bus.chipselect = 1'b0; bus.write = 1'b0; sample_valid = 1'b0;
      check("t5b_trig", 16'(triggered), 16'h0);
      reg_read(3'd4, rv); check("t5b_status_pre", rv, 16'h0001);

      // Later register writes do not disturb the running capture; then reset in ARMED
      reg_write(3'd0, 16'h0001);
      reg_write(3'd2, 16'h0005);
      for (int i = 0; i < 5; i++) push(12'(i * 256), 12'h000);
      reg_read(3'd4, rv); check("t6_status_armed", rv, 16'h0002);
      rd_ch = 1'b0; rd_addr = 4'd2;
      reset = 1'b1;
      tick();
      check("t6_rst_readdata", bus.readdata, 16'h0);
      check("t6_rst_rd_data", 16'(rd_data), 16'h0);
      check("t6_rst_trig", 16'(triggered), 16'h0);
      check("t6_rst_ready", 16'(frame_ready), 16'h0);
      reset = 1'b0;
      reg_read(3'd4, rv); check("t6_status", rv, 16'h0000);
      reg_read(3'd2, rv); check("t6_decim", rv, 16'h0001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
